// File: rtl/snake_step_engine.sv
// snake_step_engine
//   Snake movement, growth and collision engine. The body is kept twice: as a
//   coordinate ring buffer (head pushed, tail popped) and as an occupancy
//   bitmap used for self-collision and rendering. One move per i_Step strobe,
//   taking three cycles (RUN -> CHECK -> MOVE).
//
// Ports
//   Game_Clk              game clock
//   i_Rst_L               asynchronous active-low reset
//   i_Start               (re)initialise and start a game, priority over i_Step
//   i_Step                request one move (only honoured in RUN)
//   i_Dir                 00 up, 01 down, 10 left, 11 right
//   i_Food_X/Y            food cell, sampled in CHECK
//   o_Head_X/Y, o_Tail_X/Y  current head and tail cells
//   o_Length              segment count
//   o_Board               occupancy bitmap, bit index = x + y*GRID_W
//   o_Ate                 one-cycle pulse after a move that ate the food
//   o_Collision           game over, held until next start
//   o_Win                 maximum length reached, held until next start
//   o_Busy                high in INIT, CHECK and MOVE
//
// Build option
//   SNAKE_WRAP_EN         when defined, moves off an edge wrap to the opposite
//                         edge and walls never collide.
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for i_Start
// INIT    | load spawn cell, clear board and flags
// RUN     | waiting for i_Step; computes the next head on a strobe
// CHECK   | wall / self / food evaluation of the next head
// MOVE    | commit head push, tail pop, length and bitmap
// DEAD    | collision, everything frozen
// WIN     | full length reached, everything frozen
module snake_step_engine #(
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 10,
    parameter int COORD_W = 4,
    parameter int MAX_LEN = 32,
    parameter int START_X = 4,
    parameter int START_Y = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int BOARD_N = GRID_W * GRID_H
) (
    input  logic               Game_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic               i_Step,
    input  logic [1:0]         i_Dir,
    input  logic [COORD_W-1:0] i_Food_X,
    input  logic [COORD_W-1:0] i_Food_Y,
    output logic [COORD_W-1:0] o_Head_X,
    output logic [COORD_W-1:0] o_Head_Y,
    output logic [COORD_W-1:0] o_Tail_X,
    output logic [COORD_W-1:0] o_Tail_Y,
    output logic [LEN_W-1:0]   o_Length,
    output logic [BOARD_N-1:0] o_Board,
    output logic               o_Ate,
    output logic               o_Collision,
    output logic               o_Win,
    output logic               o_Busy
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int IDX_W = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [COORD_W:0]   GRID_W_X    = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0]   GRID_H_X    = (COORD_W + 1)'(GRID_H);
    localparam logic [COORD_W-1:0] START_XC    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC    = COORD_W'(START_Y);
    localparam logic [PTR_W-1:0]   PTR_LAST    = PTR_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0]   LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_LAST    = LEN_W'(MAX_LEN - 1);
    localparam logic [BOARD_N-1:0] BOARD_START =
        {{(BOARD_N - 1){1'b0}}, 1'b1} << (START_X + START_Y * GRID_W);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_CHECK, S_MOVE, S_DEAD, S_WIN
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] head_x_q, head_y_q, tail_x_q, tail_y_q;
    logic [COORD_W-1:0] nxt_x_q, nxt_y_q;
    logic [LEN_W-1:0]   len_q;
    logic [BOARD_N-1:0] board_q;
    logic [1:0]         dir_q;
    logic [PTR_W-1:0]   hp_q, tp_q;
    logic               wall_q, eat_q, ate_q, col_q, win_q;

    logic [COORD_W-1:0] ring_x [MAX_LEN];
    logic [COORD_W-1:0] ring_y [MAX_LEN];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return IDX_W'(x) + IDX_W'(y) * IDX_W'(GRID_W);
    endfunction

    // Next-head computation for a strobe in RUN. The +-1 is done one bit wider
    // so that 0-1 shows up as a large value and fails the range check.
    logic [1:0]     dir_sel;
    logic [COORD_W:0] cx, cy;
    logic           step_wall;

    always_comb begin
        dir_sel   = i_Dir;
        cx        = {1'b0, head_x_q};
        cy        = {1'b0, head_y_q};
        step_wall = 1'b0;
        if (len_q > LEN_ONE && i_Dir == (dir_q ^ 2'b01))
            dir_sel = dir_q;
        case (dir_sel)
            DIR_UP:   cy = cy - 1'b1;
            DIR_DOWN: cy = cy + 1'b1;
            DIR_LEFT: cx = cx - 1'b1;
            default:  cx = cx + 1'b1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (cx >= GRID_W_X)
            cx = (dir_sel == DIR_LEFT) ? GRID_W_X - 1'b1 : '0;
        if (cy >= GRID_H_X)
            cy = (dir_sel == DIR_UP) ? GRID_H_X - 1'b1 : '0;
`else
        step_wall = (cx >= GRID_W_X) || (cy >= GRID_H_X);
`endif
    end

    // CHECK evaluation
    logic [IDX_W-1:0] nxt_idx, tail_idx;
    logic             food_hit, occupied, at_tail, self_hit;

    always_comb begin
        nxt_idx  = cell_idx(nxt_x_q, nxt_y_q);
        tail_idx = cell_idx(tail_x_q, tail_y_q);
        food_hit = ({1'b0, i_Food_X} < GRID_W_X) && ({1'b0, i_Food_Y} < GRID_H_X) &&
                   (i_Food_X == nxt_x_q) && (i_Food_Y == nxt_y_q);
        occupied = wall_q ? 1'b0 : board_q[nxt_idx];
        at_tail  = (nxt_x_q == tail_x_q) && (nxt_y_q == tail_y_q);
        // Stepping onto the tail is legal when it moves away this same step.
        self_hit = occupied && !(at_tail && !food_hit);
    end

    // MOVE commit values
    logic [PTR_W-1:0]   hp_inc, tp_inc;
    logic [COORD_W-1:0] new_tail_x, new_tail_y;
    logic [BOARD_N-1:0] board_move;
    logic               do_move;

    always_comb begin
        hp_inc  = ptr_inc(hp_q);
        tp_inc  = ptr_inc(tp_q);
        do_move = (state_q == S_MOVE) && !i_Start;
        // A length-1 snake's new tail is the head being pushed this cycle,
        // which is not in the ring yet.
        if (tp_inc == hp_inc) begin
            new_tail_x = nxt_x_q;
            new_tail_y = nxt_y_q;
        end else begin
            new_tail_x = ring_x[tp_inc];
            new_tail_y = ring_y[tp_inc];
        end
        board_move = board_q;
        if (!eat_q)
            board_move[tail_idx] = 1'b0;
        board_move[nxt_idx] = 1'b1;
    end

    // FSM
    always_ff @(posedge Game_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_Busy  = 1'b0;
        if (i_Start) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT:  state_d = S_RUN;
                S_RUN:   if (i_Step) state_d = S_CHECK;
                S_CHECK: state_d = (wall_q || self_hit) ? S_DEAD : S_MOVE;
                S_MOVE:  state_d = (eat_q && len_q == LEN_LAST) ? S_WIN : S_RUN;
                default: state_d = state_q;
            endcase
        end
        case (state_q)
            S_INIT, S_CHECK, S_MOVE: o_Busy = 1'b1;
            default:                 o_Busy = 1'b0;
        endcase
    end

    // Ring storage needs no reset: slots are only read after being written.
    always_ff @(posedge Game_Clk) begin
        if (state_q == S_INIT) begin
            ring_x[0] <= START_XC;
            ring_y[0] <= START_YC;
        end else if (do_move) begin
            ring_x[hp_inc] <= nxt_x_q;
            ring_y[hp_inc] <= nxt_y_q;
        end
    end

    always_ff @(posedge Game_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            head_x_q <= '0;
            head_y_q <= '0;
            tail_x_q <= '0;
            tail_y_q <= '0;
            nxt_x_q  <= '0;
            nxt_y_q  <= '0;
            len_q    <= '0;
            board_q  <= '0;
            dir_q    <= DIR_RIGHT;
            hp_q     <= '0;
            tp_q     <= '0;
            wall_q   <= 1'b0;
            eat_q    <= 1'b0;
            ate_q    <= 1'b0;
            col_q    <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            ate_q <= do_move && eat_q;
            if (state_q == S_INIT) begin
                head_x_q <= START_XC;
                head_y_q <= START_YC;
                tail_x_q <= START_XC;
                tail_y_q <= START_YC;
                len_q    <= LEN_ONE;
                board_q  <= BOARD_START;
                dir_q    <= DIR_RIGHT;
                hp_q     <= '0;
                tp_q     <= '0;
                col_q    <= 1'b0;
                win_q    <= 1'b0;
            end else if (!i_Start) begin
                if (state_q == S_RUN && i_Step) begin
                    dir_q   <= dir_sel;
                    nxt_x_q <= cx[COORD_W-1:0];
                    nxt_y_q <= cy[COORD_W-1:0];
                    wall_q  <= step_wall;
                end
                if (state_q == S_CHECK) begin
                    eat_q <= food_hit;
                    if (wall_q || self_hit)
                        col_q <= 1'b1;
                end
                if (do_move) begin
                    head_x_q <= nxt_x_q;
                    head_y_q <= nxt_y_q;
                    hp_q     <= hp_inc;
                    board_q  <= board_move;
                    if (eat_q) begin
                        len_q <= len_q + 1'b1;
                        if (len_q == LEN_LAST)
                            win_q <= 1'b1;
                    end else begin
                        tail_x_q <= new_tail_x;
                        tail_y_q <= new_tail_y;
                        tp_q     <= tp_inc;
                    end
                end
            end
        end
    end

    assign o_Head_X    = head_x_q;
    assign o_Head_Y    = head_y_q;
    assign o_Tail_X    = tail_x_q;
    assign o_Tail_Y    = tail_y_q;
    assign o_Length    = len_q;
    assign o_Board     = board_q;
    assign o_Ate       = ate_q;
    assign o_Collision = col_q;
    assign o_Win       = win_q;

endmodule

// File: tb/tb_snake_step_engine.sv
module tb_snake_step_engine;

    localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

    typedef struct packed {
        logic [3:0]  hx, hy, tx, ty;
        logic [5:0]  len;
        logic [99:0] board;
        logic        ate, col, win;
    } snap_t;

    logic Game_Clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 Game_Clk = ~Game_Clk;

    // main instance (MAX_LEN 32)
    logic       start0 = 0, step0_s = 0;
    logic [1:0] dir0 = 0;
    logic [3:0] fx0 = 0, fy0 = 0;
    logic [3:0] hx0, hy0, tx0, ty0;
    logic [5:0] len0;
    logic [99:0] board0;
    logic ate0, col0, win0, busy0;

    // short instance (MAX_LEN 3)
    logic       start1 = 0, step1_s = 0;
    logic [1:0] dir1 = 0;
    logic [3:0] fx1 = 0, fy1 = 0;
    logic [3:0] hx1, hy1, tx1, ty1;
    logic [1:0] len1;
    logic [99:0] board1;
    logic ate1, col1, win1, busy1;

    snake_step_engine u_dut (
        .Game_Clk(Game_Clk), .i_Rst_L(rst_n), .i_Start(start0), .i_Step(step0_s),
        .i_Dir(dir0), .i_Food_X(fx0), .i_Food_Y(fy0),
        .o_Head_X(hx0), .o_Head_Y(hy0), .o_Tail_X(tx0), .o_Tail_Y(ty0),
        .o_Length(len0), .o_Board(board0), .o_Ate(ate0), .o_Collision(col0),
        .o_Win(win0), .o_Busy(busy0)
    );

    snake_step_engine #(.MAX_LEN(3)) u_dut3 (
        .Game_Clk(Game_Clk), .i_Rst_L(rst_n), .i_Start(start1), .i_Step(step1_s),
        .i_Dir(dir1), .i_Food_X(fx1), .i_Food_Y(fy1),
        .o_Head_X(hx1), .o_Head_Y(hy1), .o_Tail_X(tx1), .o_Tail_Y(ty1),
        .o_Length(len1), .o_Board(board1), .o_Ate(ate1), .o_Collision(col1),
        .o_Win(win1), .o_Busy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    snap_t q0[$], q1[$];
    string n0[$], n1[$];
    event  snap0, snap1;
    logic  busy_prev0 = 0, busy_prev1 = 0;

    function automatic logic [99:0] b(input int x, input int y);
        logic [99:0] v;
        v = '0;
        v[7'(x + 10 * y)] = 1'b1;
        return v;
    endfunction

    function automatic snap_t mk(input int hx, input int hy, input int tx, input int ty,
                                 input int len, input logic [99:0] bd,
                                 input logic ate, input logic col, input logic win);
        snap_t s;
        s.hx = 4'(hx); s.hy = 4'(hy); s.tx = 4'(tx); s.ty = 4'(ty);
        s.len = 6'(len); s.board = bd; s.ate = ate; s.col = col; s.win = win;
        return s;
    endfunction

    task automatic compare(input string n, input snap_t e, input snap_t a);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got head=(%0d,%0d) tail=(%0d,%0d) len=%0d ate=%0b col=%0b win=%0b board=%h ; want head=(%0d,%0d) tail=(%0d,%0d) len=%0d ate=%0b col=%0b win=%0b board=%h",
                     n, a.hx, a.hy, a.tx, a.ty, a.len, a.ate, a.col, a.win, a.board,
                     e.hx, e.hy, e.tx, e.ty, e.len, e.ate, e.col, e.win, e.board);
        end
    endtask

    task automatic check0();
        snap_t a;
        a = mk(int'(hx0), int'(hy0), int'(tx0), int'(ty0), int'(len0), board0, ate0, col0, win0);
        if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut unexpected_output: got head=(%0d,%0d) len=%0d ; want no output", hx0, hy0, len0);
        end else begin
            compare(n0.pop_front(), q0.pop_front(), a);
        end
    endtask

    task automatic check1();
        snap_t a;
        a = mk(int'(hx1), int'(hy1), int'(tx1), int'(ty1), int'(len1), board1, ate1, col1, win1);
        if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut3 unexpected_output: got head=(%0d,%0d) len=%0d ; want no output", hx1, hy1, len1);
        end else begin
            compare(n1.pop_front(), q1.pop_front(), a);
        end
    endtask

    // Monitors: a result is presented when o_Busy falls, or on a bench snapshot
    // request when nothing is supposed to move.
    always @(negedge Game_Clk) begin
        if (busy_prev0 && !busy0) check0();
        if (busy_prev1 && !busy1) check1();
        busy_prev0 <= busy0;
        busy_prev1 <= busy1;
    end
    always @(snap0) check0();
    always @(snap1) check1();

    task automatic expect0(input string n, input snap_t s);
        q0.push_back(s);
        n0.push_back(n);
    endtask

    task automatic expect1(input string n, input snap_t s);
        q1.push_back(s);
        n1.push_back(n);
    endtask

    task automatic do_start(input int which);
        @(negedge Game_Clk);
        if (which == 0) start0 = 1; else start1 = 1;
        @(negedge Game_Clk);
        start0 = 0;
        start1 = 0;
        repeat (3) @(negedge Game_Clk);
    endtask

    task automatic do_step(input int which, input logic [1:0] d);
        @(negedge Game_Clk);
        if (which == 0) begin dir0 = d; step0_s = 1; end
        else begin dir1 = d; step1_s = 1; end
        @(negedge Game_Clk);
        step0_s = 0;
        step1_s = 0;
        repeat (4) @(negedge Game_Clk);
    endtask

    task automatic food0(input int x, input int y);
        fx0 = 4'(x);
        fy0 = 4'(y);
    endtask

    initial begin
        repeat (3) @(negedge Game_Clk);
        expect0("reset_state", mk(0, 0, 0, 0, 0, '0, 0, 0, 0));
        -> snap0;
        @(negedge Game_Clk);
        rst_n = 1;

        // start and plain moves, food parked at (0,0)
        food0(0, 0);
        expect0("start", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        do_start(0);
        expect0("move1", mk(5, 4, 5, 4, 1, b(5, 4), 0, 0, 0));
        do_step(0, RIGHT);
        // second strobe lands while busy (MOVE) with a different direction
        expect0("move2_drop_busy", mk(6, 4, 6, 4, 1, b(6, 4), 0, 0, 0));
        @(negedge Game_Clk); dir0 = RIGHT; step0_s = 1;
        @(negedge Game_Clk); step0_s = 0;
        @(negedge Game_Clk); dir0 = UP; step0_s = 1;
        @(negedge Game_Clk); step0_s = 0;
        repeat (3) @(negedge Game_Clk);
        expect0("move3", mk(7, 4, 7, 4, 1, b(7, 4), 0, 0, 0));
        do_step(0, RIGHT);

        // eat, grow, reversal rejection, then the right wall
        expect0("restart", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        do_start(0);
        food0(5, 4);
        expect0("eat", mk(5, 4, 4, 4, 2, b(4, 4) | b(5, 4), 1, 0, 0));
        do_step(0, RIGHT);
        food0(0, 0);
        expect0("reverse_reject", mk(6, 4, 5, 4, 2, b(5, 4) | b(6, 4), 0, 0, 0));
        do_step(0, LEFT);
        expect0("to_7", mk(7, 4, 6, 4, 2, b(6, 4) | b(7, 4), 0, 0, 0));
        do_step(0, RIGHT);
        expect0("to_8", mk(8, 4, 7, 4, 2, b(7, 4) | b(8, 4), 0, 0, 0));
        do_step(0, RIGHT);
        expect0("to_9", mk(9, 4, 8, 4, 2, b(8, 4) | b(9, 4), 0, 0, 0));
        do_step(0, RIGHT);
`ifdef SNAKE_WRAP_EN
        expect0("wall_wrap", mk(0, 4, 9, 4, 2, b(9, 4) | b(0, 4), 0, 0, 0));
        do_step(0, RIGHT);
`else
        expect0("wall_dead", mk(9, 4, 8, 4, 2, b(8, 4) | b(9, 4), 0, 1, 0));
        do_step(0, RIGHT);
        do_step(0, DOWN);
        expect0("wall_frozen", mk(9, 4, 8, 4, 2, b(8, 4) | b(9, 4), 0, 1, 0));
        -> snap0;
`endif

        // tail chase in a 2x2 loop
        expect0("start_clears", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        do_start(0);
        food0(5, 4);
        expect0("grow_a", mk(5, 4, 4, 4, 2, b(4, 4) | b(5, 4), 1, 0, 0));
        do_step(0, RIGHT);
        food0(5, 5);
        expect0("grow_b", mk(5, 5, 4, 4, 3, b(4, 4) | b(5, 4) | b(5, 5), 1, 0, 0));
        do_step(0, DOWN);
        food0(4, 5);
        expect0("grow_c", mk(4, 5, 4, 4, 4, b(4, 4) | b(5, 4) | b(5, 5) | b(4, 5), 1, 0, 0));
        do_step(0, LEFT);
        food0(0, 0);
        expect0("tail_chase", mk(4, 4, 5, 4, 4, b(4, 4) | b(5, 4) | b(5, 5) | b(4, 5), 0, 0, 0));
        do_step(0, UP);

        // length 5, then turn into its own body
        food0(3, 4);
        expect0("grow_d", mk(3, 4, 5, 4, 5, b(5, 4) | b(5, 5) | b(4, 5) | b(4, 4) | b(3, 4), 1, 0, 0));
        do_step(0, LEFT);
        food0(0, 0);
        expect0("move_down", mk(3, 5, 5, 5, 5, b(5, 5) | b(4, 5) | b(4, 4) | b(3, 4) | b(3, 5), 0, 0, 0));
        do_step(0, DOWN);
        expect0("self_hit", mk(3, 5, 5, 5, 5, b(5, 5) | b(4, 5) | b(4, 4) | b(3, 4) | b(3, 5), 0, 1, 0));
        do_step(0, RIGHT);
        do_step(0, UP);
        expect0("self_frozen", mk(3, 5, 5, 5, 5, b(5, 5) | b(4, 5) | b(4, 4) | b(3, 4) | b(3, 5), 0, 1, 0));
        -> snap0;

        // start during MOVE aborts the step (food on the path: no ate either)
        expect0("start3", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        do_start(0);
        food0(5, 4);
        expect0("abort_move", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        @(negedge Game_Clk); dir0 = RIGHT; step0_s = 1;
        @(negedge Game_Clk); step0_s = 0;
        @(negedge Game_Clk); start0 = 1;
        @(negedge Game_Clk); start0 = 0;
        repeat (3) @(negedge Game_Clk);
        food0(0, 0);
        expect0("after_abort", mk(5, 4, 5, 4, 1, b(5, 4), 0, 0, 0));
        do_step(0, RIGHT);

        // MAX_LEN = 3 instance: two eats reach the win state
        expect1("w_start", mk(4, 4, 4, 4, 1, b(4, 4), 0, 0, 0));
        do_start(1);
        fx1 = 4'd5; fy1 = 4'd4;
        expect1("w_eat1", mk(5, 4, 4, 4, 2, b(4, 4) | b(5, 4), 1, 0, 0));
        do_step(1, RIGHT);
        fx1 = 4'd6; fy1 = 4'd4;
        expect1("w_win", mk(6, 4, 4, 4, 3, b(4, 4) | b(5, 4) | b(6, 4), 1, 0, 1));
        do_step(1, RIGHT);
        do_step(1, DOWN);
        expect1("w_frozen", mk(6, 4, 4, 4, 3, b(4, 4) | b(5, 4) | b(6, 4), 0, 0, 1));
        -> snap1;

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++)
            @(negedge Game_Clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares += q0.size() + q1.size();
            vectors += q0.size() + q1.size();
            $display("FAIL pending_outputs: got %0d results missing ; want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
